reset_seq_lx45: RTL and testbench
=================================

RESET_SEQ_LX45 -- requirements
Module: reset_seq_lx45

Interface
REQ-001 SHALL have parameter PLL_RST_CYCLES, default 4, giving the number of cycles dcm_reset is held per PLL reset pulse.
REQ-002 SHALL have parameter LOCK_STABLE_CYCLES, default 1024, giving the consecutive synchronised-lock cycles required before game reset is released.
REQ-003 SHALL have parameter DEBOUNCE_CYCLES, default 65536, giving the cycles button must be stable before a level change is accepted.
REQ-004 SHALL have parameter HOLD_CYCLES, default 256, giving the game-reset hold length after a button press.
REQ-005 SHALL have parameter LOCK_TIMEOUT, default 100000, giving the WAIT_LOCK cycle limit (used only with LOCK_TIMEOUT_EN).
REQ-006 SHALL have port sysclk, input, 1 bit: the single clock, 50 MHz board clock after BUFG.
REQ-007 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-008 SHALL have port pll_locked, input, 1 bit: PLL LOCKED, asynchronous to sysclk.
REQ-009 SHALL have port button, input, 1 bit: raw active-high reset button (board switch).
REQ-010 SHALL have port dcm_reset, output, 1 bit: PLL RST, active-high.
REQ-011 SHALL have port reset, output, 1 bit: game/scan-converter/DAC reset, active-high.
REQ-012 SHALL have port state, output, 3 bits: current FSM state encoding, for LEDs.
REQ-013 SHALL have port retry_cnt, output, 4 bits: count of lock timeouts.

Function
REQ-014 SHALL pass pll_locked and button each through a 2-flop synchroniser, giving 2 cycles of input latency.
REQ-015 SHALL debounce the synchronised button, accepting a new level only after DEBOUNCE_CYCLES consecutive equal samples; a press is a debounced 0->1 transition.
REQ-016 SHALL implement the states PLL_RST=0, WAIT_LOCK=1, STABLE=2, RUN=3, HOLD=4; encodings 5-7 SHALL recover to PLL_RST on the next cycle.
REQ-017 In PLL_RST, the block SHALL drive dcm_reset=1 and reset=1 for exactly PLL_RST_CYCLES cycles, then move to WAIT_LOCK.
REQ-018 In WAIT_LOCK, the block SHALL drive dcm_reset=0 and reset=1, and move to STABLE on the first cycle the synchronised lock is 1.
REQ-019 In STABLE, the block SHALL count consecutive lock=1 cycles, return to WAIT_LOCK on lock=0, and move to RUN when the count reaches LOCK_STABLE_CYCLES.
REQ-020 reset SHALL be 0 in the first RUN cycle and remain 0 for as long as the block stays in RUN.
REQ-021 A press while in RUN SHALL move the block to HOLD, which drives reset=1 for exactly HOLD_CYCLES cycles and then returns to RUN; presses while in HOLD SHALL be ignored.
REQ-022 Synchronised lock=0 in STABLE, RUN or HOLD SHALL move the block to PLL_RST; lock loss SHALL take priority over a press arriving in the same cycle.
REQ-023 dcm_reset and reset SHALL be registered outputs decoded from the next state, so they are glitch-free.
REQ-024 All counters SHALL be sized with $clog2 of their parameter and SHALL clear on every state entry.

Reset
REQ-025 reset_n low SHALL asynchronously force state=PLL_RST, dcm_reset=1, reset=1, retry_cnt=0, all counters and synchronisers to 0, and the debounced level to 0.
REQ-026 The reset_n release SHALL be synchronised (asserted asynchronously, deasserted after 2 sysclk edges); the PLL_RST count SHALL begin after that release.
REQ-027 reset_n asserted mid-sequence SHALL abort any state and restart from PLL_RST on release.

Configuration
REQ-028 With LOCK_TIMEOUT_EN defined, LOCK_TIMEOUT cycles in WAIT_LOCK without lock SHALL return the block to PLL_RST and increment retry_cnt, saturating at 15.
REQ-029 Without LOCK_TIMEOUT_EN, WAIT_LOCK SHALL wait indefinitely, retry_cnt SHALL be tied to 0, and no timeout counter SHALL be synthesised.

Structure
REQ-030 The state encodings and the retry_cnt width SHALL live in the shared package ff_pkg.
REQ-031 The synchroniser and debouncer SHALL be one sub-module, sync_debounce, with a DEBOUNCE_CYCLES parameter, instantiated once for button; pll_locked SHALL use only the 2-flop stage.

Verification (parameters 4/8/16/32/100)
REQ-032 Release reset_n with lock high -> dcm_reset=1 for 4 cycles; reset falls exactly 2+4+2+1+8 cycles after release; state=3.
REQ-033 In RUN, 20-cycle button pulse -> state=4, reset=1 for 32 cycles, back to state=3; a 10-cycle pulse -> no change.
REQ-034 In RUN, drop lock for 1 cycle -> state=0 two cycles later, dcm_reset=1 for 4 cycles, then full re-lock sequence.
REQ-035 In STABLE, lock glitches low at count 5 -> state=1, count restarts; reset stays 1.
REQ-036 With LOCK_TIMEOUT_EN and lock held low -> PLL_RST every 104 cycles; retry_cnt reaches 15 and holds.
REQ-037 Lock loss and a debounced press in the same cycle -> state=0; no HOLD entry.

Source files
------------

// File: rtl/ff_pkg.sv
// Shared definitions for the LX45 reset sequencer: FSM state encodings,
// retry counter width and the counter-width helper.
package ff_pkg;

    localparam int STATE_W = 3;
    localparam int RETRY_W = 4;
    localparam logic [RETRY_W-1:0] RETRY_MAX = '1;

    typedef enum logic [STATE_W-1:0] {
        ST_PLL_RST   = 3'd0,
        ST_WAIT_LOCK = 3'd1,
        ST_STABLE    = 3'd2,
        ST_RUN       = 3'd3,
        ST_HOLD      = 3'd4
    } state_e;

    // Width of a counter running 0..n-1; a 1-cycle count still needs one bit.
    function automatic int cnt_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/sync_debounce.sv
// Two-flop synchroniser plus debouncer for a raw board switch; emits a
// one-cycle pulse when the debounced level rises.
module sync_debounce
    import ff_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 65536
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_press
);

    localparam int DB_W = cnt_w(DEBOUNCE_CYCLES);
    localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]      r_sync;
    logic [DB_W-1:0] r_cnt;
    logic            r_level;
    logic            r_press;
    logic            w_sync;

    assign w_sync  = r_sync[1];
    assign o_press = r_press;

    // NOTE: sequential state is updated with <= only, so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_sync  <= '0;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_press <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_raw};
            r_press <= 1'b0;
            if (w_sync == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == DB_LAST) begin
                // DEBOUNCE_CYCLES consecutive samples disagreed with the held level.
                r_level <= w_sync;
                r_press <= w_sync;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/reset_seq_lx45.sv
// Power-on / PLL reset sequencer for the LX45 board. Define LOCK_TIMEOUT_EN
// to bound WAIT_LOCK by LOCK_TIMEOUT cycles and count retries on retry_cnt.
module reset_seq_lx45
    import ff_pkg::*;
#(
    parameter int PLL_RST_CYCLES     = 4,
    parameter int LOCK_STABLE_CYCLES = 1024,
    parameter int DEBOUNCE_CYCLES    = 65536,
    parameter int HOLD_CYCLES        = 256,
    parameter int LOCK_TIMEOUT       = 100000
) (
    input  logic               sysclk,
    input  logic               reset_n,
    input  logic               pll_locked,
    input  logic               button,
    output logic               dcm_reset,
    output logic               reset,
    output logic [STATE_W-1:0] state,
    output logic [RETRY_W-1:0] retry_cnt
);

    localparam int PLL_W    = cnt_w(PLL_RST_CYCLES);
    localparam int STABLE_W = cnt_w(LOCK_STABLE_CYCLES);
    localparam int HOLD_W   = cnt_w(HOLD_CYCLES);

    localparam logic [PLL_W-1:0]    PLL_LAST    = PLL_W'(PLL_RST_CYCLES - 1);
    localparam logic [STABLE_W-1:0] STABLE_LAST = STABLE_W'(LOCK_STABLE_CYCLES - 1);
    localparam logic [HOLD_W-1:0]   HOLD_LAST   = HOLD_W'(HOLD_CYCLES - 1);

    if (PLL_RST_CYCLES < 1 || LOCK_STABLE_CYCLES < 1 || DEBOUNCE_CYCLES < 1 ||
        HOLD_CYCLES < 1 || LOCK_TIMEOUT < 1) begin : g_bad_param
        $error("reset_seq_lx45: every cycle parameter must be at least 1");
    end

    logic [1:0]          r_rst_sync;
    logic                w_rst_n;
    logic [1:0]          r_lock_sync;
    logic                w_lock;
    logic                w_press;
    logic                w_timeout;
    state_e              r_state;
    state_e              w_next;
    logic                r_dcm_reset;
    logic                r_reset;
    logic [PLL_W-1:0]    r_pll_cnt;
    logic [STABLE_W-1:0] r_stable_cnt;
    logic [HOLD_W-1:0]   r_hold_cnt;

    // Reset asserts asynchronously but releases two sysclk edges later.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) r_rst_sync <= '0;
        else          r_rst_sync <= {r_rst_sync[0], 1'b1};
    end
    assign w_rst_n = r_rst_sync[1];

    // A PLL held in reset reports stale LOCKED, so the synchroniser is
    // flushed while dcm_reset is high and lock is re-qualified afterwards.
    always_ff @(posedge sysclk or negedge w_rst_n) begin
        if (!w_rst_n)         r_lock_sync <= '0;
        else if (r_dcm_reset) r_lock_sync <= '0;
        else                  r_lock_sync <= {r_lock_sync[0], pll_locked};
    end
    assign w_lock = r_lock_sync[1];

    sync_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_button (
        .i_clk  (sysclk),
        .i_rst_n(w_rst_n),
        .i_raw  (button),
        .o_press(w_press)
    );

    // NOTE: w_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        w_next = ST_PLL_RST;
        case (r_state)
            ST_PLL_RST:   w_next = (r_pll_cnt == PLL_LAST) ? ST_WAIT_LOCK : ST_PLL_RST;
            ST_WAIT_LOCK: begin
                if (w_lock)         w_next = ST_STABLE;
                else if (w_timeout) w_next = ST_PLL_RST;
                else                w_next = ST_WAIT_LOCK;
            end
            ST_STABLE: begin
                if (!w_lock)                          w_next = ST_WAIT_LOCK;
                else if (r_stable_cnt == STABLE_LAST) w_next = ST_RUN;
                else                                  w_next = ST_STABLE;
            end
            ST_RUN: begin
                // Lock loss outranks a press landing in the same cycle.
                if (!w_lock)      w_next = ST_PLL_RST;
                else if (w_press) w_next = ST_HOLD;
                else              w_next = ST_RUN;
            end
            ST_HOLD: begin
                if (!w_lock)                     w_next = ST_PLL_RST;
                else if (r_hold_cnt == HOLD_LAST) w_next = ST_RUN;
                else                             w_next = ST_HOLD;
            end
            default:      w_next = ST_PLL_RST;
        endcase
    end

    // Outputs decode w_next so they change on the same edge as the state.
    always_ff @(posedge sysclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_state      <= ST_PLL_RST;
            r_dcm_reset  <= 1'b1;
            r_reset      <= 1'b1;
            r_pll_cnt    <= '0;
            r_stable_cnt <= '0;
            r_hold_cnt   <= '0;
        end else begin
            r_state      <= w_next;
            r_dcm_reset  <= (w_next == ST_PLL_RST);
            r_reset      <= (w_next != ST_RUN);
            r_pll_cnt    <= (r_state == ST_PLL_RST && w_next == ST_PLL_RST) ? r_pll_cnt + 1'b1 : '0;
            r_stable_cnt <= (r_state == ST_STABLE && w_next == ST_STABLE) ? r_stable_cnt + 1'b1 : '0;
            r_hold_cnt   <= (r_state == ST_HOLD && w_next == ST_HOLD) ? r_hold_cnt + 1'b1 : '0;
        end
    end

`ifdef LOCK_TIMEOUT_EN
    localparam int TO_W = cnt_w(LOCK_TIMEOUT);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(LOCK_TIMEOUT - 1);

    logic [TO_W-1:0]    r_timeout_cnt;
    logic [RETRY_W-1:0] r_retry_cnt;

    assign w_timeout = (r_state == ST_WAIT_LOCK) && (r_timeout_cnt == TO_LAST);

    always_ff @(posedge sysclk or negedge w_rst_n) begin
        if (!w_rst_n) begin
            r_timeout_cnt <= '0;
            r_retry_cnt   <= '0;
        end else begin
            r_timeout_cnt <= (r_state == ST_WAIT_LOCK && w_next == ST_WAIT_LOCK) ?
                             r_timeout_cnt + 1'b1 : '0;
            if (r_state == ST_WAIT_LOCK && w_next == ST_PLL_RST && r_retry_cnt != RETRY_MAX)
                r_retry_cnt <= r_retry_cnt + 1'b1;
        end
    end
    assign retry_cnt = r_retry_cnt;
`else
    assign w_timeout = 1'b0;
    assign retry_cnt = '0;
`endif

    assign dcm_reset = r_dcm_reset;
    assign reset     = r_reset;
    assign state     = r_state;

endmodule

// File: tb/tb_reset_seq_lx45.sv
// Directed bench for reset_seq_lx45 with parameters 4/8/16/32/100.
module tb_reset_seq_lx45;

    logic       sysclk = 1'b0;
    logic       reset_n;
    logic       pll_locked;
    logic       button;
    logic       dcm_reset;
    logic       reset;
    logic [2:0] state;
    logic [3:0] retry_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    reset_seq_lx45 #(
        .PLL_RST_CYCLES    (4),
        .LOCK_STABLE_CYCLES(8),
        .DEBOUNCE_CYCLES   (16),
        .HOLD_CYCLES       (32),
        .LOCK_TIMEOUT      (100)
    ) dut (
        .sysclk    (sysclk),
        .reset_n   (reset_n),
        .pll_locked(pll_locked),
        .button    (button),
        .dcm_reset (dcm_reset),
        .reset     (reset),
        .state     (state),
        .retry_cnt (retry_cnt)
    );

    always #5 sysclk = ~sysclk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Sample 1 ns after the rising edge; inputs also change here.
    task automatic tick();
        @(posedge sysclk);
        #1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int t_dcm_fall, t_stable, t_rst_fall, t_hold, t_pll, n_hi, n_bad, s2, s18, s19;
        bit saw_hold;

        reset_n    = 1'b0;
        pll_locked = 1'b1;
        button     = 1'b0;
        repeat (3) tick();
        check("rst_state", state, 0);
        check("rst_dcm", dcm_reset, 1);
        check("rst_reset", reset, 1);
        check("rst_retry", retry_cnt, 0);

        // Power-up with lock high: 2 sync + 4 PLL_RST + 2 lock sync + 1 + 8 STABLE.
        reset_n = 1'b1;
        t_dcm_fall = -1; t_stable = -1; t_rst_fall = -1;
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (t_dcm_fall < 0 && !dcm_reset) t_dcm_fall = t;
            if (t_stable < 0 && state == 3'd2) t_stable = t;
            if (t_rst_fall < 0 && !reset) t_rst_fall = t;
        end
        check("pwr_dcm_fall", t_dcm_fall, 6);
        check("pwr_stable_entry", t_stable, 9);
        check("pwr_reset_fall", t_rst_fall, 17);
        check("pwr_run_state", state, 3);

        // 20-cycle press: HOLD after 2 sync + 16 debounce + 1, reset high 32 cycles.
        button = 1'b1;
        t_hold = -1; n_hi = 0;
        for (int t = 1; t <= 80; t++) begin
            tick();
            if (t == 20) button = 1'b0;
            if (t_hold < 0 && state == 3'd4) t_hold = t;
            if (reset) n_hi++;
        end
        check("hold_entry", t_hold, 19);
        check("hold_reset_len", n_hi, 32);
        check("hold_back_run", state, 3);

        // 10-cycle pulse is rejected by the debouncer.
        button = 1'b1;
        n_bad = 0;
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (t == 10) button = 1'b0;
            if (state != 3'd3 || reset) n_bad++;
        end
        check("short_pulse_ignored", n_bad, 0);

        // One-cycle lock drop in RUN.
        pll_locked = 1'b0;
        t_pll = -1; n_hi = 0; t_rst_fall = -1; s2 = -1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t == 1) pll_locked = 1'b1;
            if (t == 2) s2 = state;
            if (t_pll < 0 && state == 3'd0) t_pll = t;
            if (dcm_reset) n_hi++;
            if (t_pll > 0 && t_rst_fall < 0 && !reset) t_rst_fall = t;
        end
        check("drop_state_before", s2, 3);
        check("drop_pll_entry", t_pll, 3);
        check("drop_dcm_len", n_hi, 4);
        check("drop_relock_fall", t_rst_fall, 18);
        check("drop_run_state", state, 3);

        // Press and lock loss reach the FSM on the same edge.
        button = 1'b1;
        saw_hold = 1'b0; s18 = -1; s19 = -1;
        for (int t = 1; t <= 60; t++) begin
            tick();
            if (t == 16) pll_locked = 1'b0;
            if (t == 17) pll_locked = 1'b1;
            if (t == 25) button = 1'b0;
            if (t == 18) s18 = state;
            if (t == 19) s19 = state;
            if (state == 3'd4) saw_hold = 1'b1;
        end
        check("tie_state_before", s18, 3);
        check("tie_lock_wins", s19, 0);
        check("tie_no_hold", saw_hold, 0);
        check("tie_run_again", state, 3);

        // Reset_n mid-HOLD aborts asynchronously.
        button = 1'b1;
        repeat (20) tick();
        button = 1'b0;
        repeat (5) tick();
        check("abort_in_hold", state, 4);
        reset_n = 1'b0;
        #2;
        check("abort_state", state, 0);
        check("abort_dcm", dcm_reset, 1);
        check("abort_reset", reset, 1);
        repeat (3) tick();

        // Lock glitch in STABLE at count 5 restarts qualification.
        reset_n = 1'b1;
        s2 = -1; s18 = -1; n_bad = 0; t_rst_fall = -1;
        for (int t = 1; t <= 40; t++) begin
            tick();
            if (t == 12) pll_locked = 1'b0;
            if (t == 13) pll_locked = 1'b1;
            if (t == 14) s2 = state;
            if (t == 15) s18 = state;
            if (t < 24 && !reset) n_bad++;
            if (t_rst_fall < 0 && !reset) t_rst_fall = t;
        end
        check("glitch_in_stable", s2, 2);
        check("glitch_to_wait", s18, 1);
        check("glitch_reset_held", n_bad, 0);
        check("glitch_reset_fall", t_rst_fall, 24);

        // Lock held low from power-up.
        reset_n    = 1'b0;
        pll_locked = 1'b0;
        repeat (3) tick();
        reset_n = 1'b1;
`ifdef LOCK_TIMEOUT_EN
        begin
            int first_to, second_to, prev;
            first_to = -1; second_to = -1; prev = 0;
            for (int t = 1; t <= 1800; t++) begin
                tick();
                if (prev == 1 && state == 3'd0) begin
                    if (first_to < 0) first_to = t;
                    else if (second_to < 0) second_to = t;
                end
                prev = state;
            end
            check("timeout_first", first_to, 106);
            check("timeout_second", second_to, 210);
            check("retry_saturated", retry_cnt, 15);
        end
`else
        n_bad = 0;
        for (int t = 1; t <= 300; t++) begin
            tick();
            if (t > 6 && state != 3'd1) n_bad++;
        end
        check("nolock_waits", n_bad, 0);
        check("nolock_retry", retry_cnt, 0);
        check("nolock_dcm", dcm_reset, 0);
        check("nolock_reset", reset, 1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
